// File: rtl/mem_bus_arbiter.sv
// Arbitrates NCH request channels onto one memory port (fixed priority or round-robin).
// Latency: grant in IDLE, WAIT_STATES+1 ACCESS cycles, 1-cycle ack in DONE; losers hold iReq until served.
module mem_bus_arbiter #(
  parameter int NCH         = 2,
  parameter int WAIT_STATES = 1,
  parameter int RR_MODE     = 0
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [NCH-1:0]    iReq,
  input  logic [NCH-1:0]    iWe,
  input  logic [4*NCH-1:0]  iByteEnable,
  input  logic [32*NCH-1:0] iAddress,
  input  logic [32*NCH-1:0] iWriteData,
  output logic [NCH-1:0]    oAck,
  output logic [31:0]       oReadData,
  output logic              oBusy,
  output logic [2:0]        oGrant,
  output logic              oMemReadEnable,
  output logic              oMemWriteEnable,
  output logic [3:0]        oMemByteEnable,
  output logic [31:0]       oMemAddress,
  output logic [31:0]       oMemWriteData,
  input  logic [31:0]       iMemReadData
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

  state_t          state_q, state_d;
  logic [2:0]      grant_q, grant_d;
  logic [2:0]      ptr_q, ptr_d;
  logic [3:0]      wcnt_q, wcnt_d;
  logic            we_q, we_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [NCH-1:0]  ack_q, ack_d;
  logic            busy_q, busy_d;
  logic            mem_re_q, mem_re_d;
  logic            mem_we_q, mem_we_d;

  logic            sel_vld;
  logic [2:0]      sel_idx;
  logic [3:0]      cand;
  logic            sel_we;
  logic [3:0]      sel_be;
  logic [31:0]     sel_addr;
  logic [31:0]     sel_wdata;

  // Candidates are scanned farthest-first so the nearest requester overwrites the selection.
  always_comb begin
    sel_vld   = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    sel_we    = 1'b0;
    sel_be    = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int k = NCH; k >= 1; k--) begin
      cand = (RR_MODE != 0) ? ({1'b0, ptr_q} + 4'(k)) : 4'(k - 1);
      if (cand >= 4'(NCH)) cand = cand - 4'(NCH);
      for (int c = 0; c < NCH; c++) begin
        if (iReq[c] && (cand == 4'(c))) begin
          sel_vld = 1'b1;
          sel_idx = 3'(c);
        end
      end
    end
    for (int c = 0; c < NCH; c++) begin
      if (sel_idx == 3'(c)) begin
        sel_we    = iWe[c];
        sel_be    = iByteEnable[4*c +: 4];
        sel_addr  = iAddress[32*c +: 32];
        sel_wdata = iWriteData[32*c +: 32];
      end
    end
  end

  // Enables and ack are computed for the next state so every output leaves a flop.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    wcnt_d   = wcnt_q;
    we_d     = we_q;
    be_d     = be_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    ack_d    = '0;
    busy_d   = busy_q;
    mem_re_d = 1'b0;
    mem_we_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sel_vld) begin
          state_d  = ACCESS;
          grant_d  = sel_idx;
          ptr_d    = sel_idx;
          wcnt_d   = '0;
          we_d     = sel_we;
          be_d     = sel_be;
          addr_d   = sel_addr;
          wdata_d  = sel_wdata;
          busy_d   = 1'b1;
          mem_re_d = ~sel_we;
          mem_we_d = sel_we;
        end
      end
      ACCESS: begin
        wcnt_d = wcnt_q + 4'd1;
        if (wcnt_q == WAIT_CNT) begin
          state_d = DONE;
          rdata_d = we_q ? 32'd0 : iMemReadData;
          for (int c = 0; c < NCH; c++) ack_d[c] = (grant_q == 3'(c));
        end else begin
          mem_re_d = ~we_q;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      ptr_q    <= 3'(NCH - 1);
      wcnt_q   <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      ack_q    <= '0;
      busy_q   <= 1'b0;
      mem_re_q <= 1'b0;
      mem_we_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      wcnt_q   <= wcnt_d;
      we_q     <= we_d;
      be_q     <= be_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      mem_re_q <= mem_re_d;
      mem_we_q <= mem_we_d;
    end
  end

  assign oAck            = ack_q;
  assign oReadData       = rdata_q;
  assign oBusy           = busy_q;
  assign oGrant          = grant_q;
  assign oMemReadEnable  = mem_re_q;
  assign oMemWriteEnable = mem_we_q;
  assign oMemByteEnable  = be_q;
  assign oMemAddress     = addr_q;
  assign oMemWriteData   = wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: three parameter sets, each with a transaction-level model,
// directed literal cases and randomized traffic with occasional resets.
module tb_mem_bus_arbiter;

  logic clk;
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int cfg_nch(input int g);
    return (g == 1) ? 4 : 2;
  endfunction
  function automatic int cfg_ws(input int g);
    case (g)
      0:       return 1;
      1:       return 2;
      default: return 0;
    endcase
  endfunction
  function automatic int cfg_rr(input int g);
    return (g == 1) ? 1 : 0;
  endfunction

  // Hand-derived per configuration: request-to-ack cycles, read-enable width, ack spacing.
  function automatic int lit_lat(input int g);
    case (g)
      0:       return 3;
      1:       return 4;
      default: return 2;
    endcase
  endfunction
  function automatic int lit_re(input int g);
    case (g)
      0:       return 2;
      1:       return 3;
      default: return 1;
    endcase
  endfunction
  function automatic int lit_gap(input int g);
    case (g)
      0:       return 4;
      1:       return 5;
      default: return 3;
    endcase
  endfunction
  function automatic int lit_seq(input int g, input int a);
    if (g != 1) return 0;
    case (a)
      1:       return 1;
      2:       return 2;
      3:       return 3;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] init_word(input int i);
    return (i == 0) ? 32'hDEADBEEF : (32'hC0DE0000 | 32'(i));
  endfunction

  task automatic chk(input int g, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL cfg%0d %s: got 0x%08h, expected 0x%08h", g, nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : gen_cfg
    localparam int G  = g;
    localparam int N  = cfg_nch(g);
    localparam int WS = cfg_ws(g);
    localparam int RR = cfg_rr(g);

    logic            rst_n;
    logic [N-1:0]    req, we, ack;
    logic [4*N-1:0]  be;
    logic [32*N-1:0] addr, wdat;
    logic [31:0]     rdata, maddr, mwdat, mrdata;
    logic            busy, mem_re, mem_we;
    logic [2:0]      grant;
    logic [3:0]      mbe;
    logic            preload;
    bit              done_f;

    logic [31:0]     env_mem [16];
    int              re_cnt;

    int              m_phase, m_ch, m_grant, m_ptr;
    logic            m_we;
    logic [3:0]      m_be;
    logic [31:0]     m_addr, m_wdat, m_rdata;
    logic [31:0]     model_mem [16];

    mem_bus_arbiter #(.NCH(N), .WAIT_STATES(WS), .RR_MODE(RR)) dut (
      .iCLK(clk), .iRST(rst_n), .iReq(req), .iWe(we), .iByteEnable(be),
      .iAddress(addr), .iWriteData(wdat), .oAck(ack), .oReadData(rdata),
      .oBusy(busy), .oGrant(grant), .oMemReadEnable(mem_re), .oMemWriteEnable(mem_we),
      .oMemByteEnable(mbe), .oMemAddress(maddr), .oMemWriteData(mwdat),
      .iMemReadData(mrdata)
    );

    // Memory only presents real data in the final read-enable cycle; earlier cycles carry junk.
    always @(posedge clk) begin
      if (preload) begin
        for (int i = 0; i < 16; i++) env_mem[i] <= init_word(i);
      end else if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mbe[b]) env_mem[maddr[5:2]][8*b +: 8] <= mwdat[8*b +: 8];
      end
      re_cnt <= mem_re ? re_cnt + 1 : 0;
    end
    assign mrdata = (mem_re && re_cnt == WS) ? env_mem[maddr[5:2]] : (32'hBAD00000 | 32'(re_cnt));

    task automatic model_reset();
      m_phase = 0; m_ch = 0; m_grant = 0; m_ptr = N - 1;
      m_we = 1'b0; m_be = '0; m_addr = '0; m_wdat = '0; m_rdata = '0;
    endtask

    // Transaction view: phase 0 idle, 1..WS+1 memory access, WS+2 acknowledge.
    task automatic step();
      if (!rst_n) begin
        model_reset();
      end else if (m_phase == 0) begin
        if (req != '0) begin
          m_ch = -1;
          for (int k = 1; k <= N; k++) begin
            int c;
            c = (RR != 0) ? (m_ptr + k) % N : k - 1;
            if (m_ch < 0 && req[c]) m_ch = c;
          end
          m_we    = we[m_ch];
          m_be    = be[4*m_ch +: 4];
          m_addr  = addr[32*m_ch +: 32];
          m_wdat  = wdat[32*m_ch +: 32];
          m_grant = m_ch;
          m_ptr   = m_ch;
          m_phase = 1;
        end
      end else begin
        if (m_phase == 1 && m_we)
          for (int b = 0; b < 4; b++)
            if (m_be[b]) model_mem[m_addr[5:2]][8*b +: 8] = m_wdat[8*b +: 8];
        if (m_phase == WS + 1) m_rdata = m_we ? 32'd0 : model_mem[m_addr[5:2]];
        m_phase = (m_phase == WS + 2) ? 0 : m_phase + 1;
      end
    endtask

    task automatic compare();
      logic [31:0] ea;
      ea = (m_phase == WS + 2) ? (32'd1 << m_ch) : 32'd0;
      chk(G, "ack", 32'(ack), ea);
      chk(G, "busy", 32'(busy), 32'(m_phase != 0));
      chk(G, "mem_re", 32'(mem_re), 32'(m_phase >= 1 && m_phase <= WS + 1 && !m_we));
      chk(G, "mem_we", 32'(mem_we), 32'(m_phase == 1 && m_we));
      chk(G, "grant", 32'(grant), 32'(m_grant));
      chk(G, "mem_addr", maddr, m_addr);
      chk(G, "mem_be", 32'(mbe), 32'(m_be));
      chk(G, "mem_wdata", mwdat, m_wdat);
      if (m_phase == WS + 2) chk(G, "read_data", rdata, m_rdata);
    endtask

    task automatic tick();
      @(posedge clk);
      step();
      @(negedge clk);
      compare();
    endtask

    task automatic wait_ack(output int lat, output int rec, output int wec,
                            output logic [3:0] bes, output logic [31:0] acks);
      bit got;
      got = 0; lat = 0; rec = 0; wec = 0; bes = '0; acks = '0;
      while (!got && lat < 30) begin
        tick();
        lat++;
        if (mem_re) rec++;
        if (mem_we) begin wec++; bes = mbe; end
        if (ack != '0) begin got = 1; acks = 32'(ack); end
      end
      chk(G, "ack_timeout", 32'(got), 32'd1);
    endtask

    task automatic rand_drive();
      bit inflight;
      bit next_rst;
      next_rst = !rst_n || ($urandom_range(119) != 0);
      for (int c = 0; c < N; c++) begin
        inflight = (m_phase != 0) && (m_ch == c);
        if (req[c]) begin
          if (inflight && (m_phase == WS + 2 || $urandom_range(9) == 0)) req[c] = 1'b0;
        end else begin
          we[c]            = 1'($urandom_range(1));
          be[4*c +: 4]     = 4'($urandom_range(15));
          addr[32*c +: 32] = $urandom & 32'hFFFF_FFFC;
          wdat[32*c +: 32] = $urandom;
          if (!inflight && $urandom_range(3) == 0) req[c] = 1'b1;
        end
      end
      rst_n = next_rst;
    endtask

    initial begin
      int          lat, rec, wec, gi;
      logic [3:0]  bes;
      logic [31:0] acks;
      done_f = 1'b0; rst_n = 1'b0; preload = 1'b1;
      req = '0; we = '0; be = '0; addr = '0; wdat = '0;
      for (int i = 0; i < 16; i++) model_mem[i] = init_word(i);
      model_reset();
      tick();
      tick();
      chk(G, "rst_busy", 32'(busy), 32'd0);
      chk(G, "rst_ack", 32'(ack), 32'd0);
      chk(G, "rst_grant", 32'(grant), 32'd0);
      chk(G, "rst_rdata", rdata, 32'd0);
      chk(G, "rst_enables", {30'd0, mem_re, mem_we}, 32'd0);
      chk(G, "rst_addr", maddr, 32'd0);
      preload = 1'b0;
      rst_n = 1'b1;

      // single read of 0x100
      addr[31:0] = 32'h100; be[3:0] = 4'hF; we[0] = 1'b0; req[0] = 1'b1;
      wait_ack(lat, rec, wec, bes, acks);
      chk(G, "rd_latency", 32'(lat), 32'(lit_lat(G)));
      chk(G, "rd_re_cycles", 32'(rec), 32'(lit_re(G)));
      chk(G, "rd_ack", acks, 32'd1);
      chk(G, "rd_data", rdata, 32'hDEADBEEF);
      req[0] = 1'b0;
      tick();

      // ch1 partial write of 0x200, then read it back through ch0
      addr[63:32] = 32'h200; wdat[63:32] = 32'h12345678; be[7:4] = 4'b0011; we[1] = 1'b1; req[1] = 1'b1;
      wait_ack(lat, rec, wec, bes, acks);
      chk(G, "wr_we_cycles", 32'(wec), 32'd1);
      chk(G, "wr_re_cycles", 32'(rec), 32'd0);
      chk(G, "wr_byte_en", 32'(bes), 32'h3);
      chk(G, "wr_ack", acks, 32'd2);
      chk(G, "wr_rdata_zero", rdata, 32'd0);
      req[1] = 1'b0; we[1] = 1'b0;
      tick();
      addr[31:0] = 32'h200; req[0] = 1'b1;
      wait_ack(lat, rec, wec, bes, acks);
      chk(G, "rbw_data", rdata, 32'hDEAD5678);
      req[0] = 1'b0;
      tick();

      // reset for one cycle during a ch0 read; ch0 keeps requesting
      addr[31:0] = 32'h104; req[0] = 1'b1;
      tick();
      rst_n = 1'b0;
      #1;
      chk(G, "abort_re", 32'(mem_re), 32'd0);
      chk(G, "abort_busy", 32'(busy), 32'd0);
      tick();
      chk(G, "abort_ack", 32'(ack), 32'd0);
      rst_n = 1'b1;
      wait_ack(lat, rec, wec, bes, acks);
      chk(G, "rearb_latency", 32'(lat), 32'(lit_lat(G)));
      chk(G, "rearb_ack", acks, 32'd1);
      chk(G, "rearb_data", rdata, 32'hC0DE0001);
      req[0] = 1'b0;
      tick();

      // all channels request continuously from a fresh reset
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < N; c++) begin
        addr[32*c +: 32] = 32'h100 + 32'(4 * c);
        be[4*c +: 4] = 4'hF; we[c] = 1'b0; req[c] = 1'b1;
      end
      for (int a = 0; a < 5; a++) begin
        wait_ack(lat, rec, wec, bes, acks);
        gi = -1;
        for (int c = 0; c < N; c++) if (acks[c]) gi = c;
        chk(G, "arb_order", 32'(gi), 32'(lit_seq(G, a)));
        chk(G, "arb_onehot", 32'($countones(acks)), 32'd1);
        chk(G, (a == 0) ? "arb_first_lat" : "arb_spacing", 32'(lat),
            32'((a == 0) ? lit_lat(G) : lit_gap(G)));
      end
      req = '0;
      tick();
      tick();

      repeat (600) begin
        rand_drive();
        tick();
      end
      req = '0;
      rst_n = 1'b1;
      repeat (10) tick();
      done_f = 1'b1;
    end
  end

  initial begin
    bit all_done;
    all_done = 1'b0;
    for (int t = 0; t < 6000 && !all_done; t++) begin
      @(posedge clk);
      all_done = gen_cfg[0].done_f && gen_cfg[1].done_f && gen_cfg[2].done_f;
    end
    chk(3, "run_complete", 32'(all_done), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter NCH, default 2, number of requester channels (2..8).
REQ-002 SHALL have parameter WAIT_STATES, default 1, memory read latency in extra cycles (0..15).
REQ-003 SHALL have parameter RR_MODE, default 0: 0 = fixed priority, 1 = round-robin.
REQ-004 SHALL have port iCLK  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port iRST  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port iReq  input  NCH  per-channel request, held until that channel's oAck.
REQ-007 SHALL have port iWe  input  NCH  per-channel write (1) / read (0).
REQ-008 SHALL have port iByteEnable  input  4*NCH  per-channel byte enables, channel k at [4k+3:4k].
REQ-009 SHALL have port iAddress  input  32*NCH  per-channel address, channel k at [32k+31:32k].
REQ-010 SHALL have port iWriteData  input  32*NCH  per-channel write data, same packing.
REQ-011 SHALL have port oAck  output  NCH  one-cycle completion pulse for the channel served.
REQ-012 SHALL have port oReadData  output  32  read data, valid while any oAck bit is 1.
REQ-013 SHALL have port oBusy  output  1  high in every state except IDLE.
REQ-014 SHALL have port oGrant  output  3  index of the channel currently or last served.
REQ-015 SHALL have ports oMemReadEnable (output, 1), oMemWriteEnable (output, 1), oMemByteEnable (output, 4), oMemAddress (output, 32), oMemWriteData (output, 32) and iMemReadData (input, 32); together these form the single shared memory port.

Function
REQ-016 SHALL implement FSM states IDLE, ACCESS and DONE.
REQ-017 IDLE: when any iReq bit is 1, SHALL select one channel, latch its iWe, iByteEnable, iAddress and iWriteData into internal registers, set oGrant, clear the wait counter, and go to ACCESS on the next edge.
REQ-018 Fixed mode SHALL pick the lowest-index requesting channel.
REQ-019 Round-robin mode SHALL search from (last granted + 1) mod NCH upward with wrap-around; after reset the pointer SHALL be NCH-1, so channel 0 is searched first.
REQ-020 ACCESS: the memory address, byte-enable and write-data ports SHALL be driven only from the latched registers.
REQ-021 ACCESS read: oMemReadEnable SHALL be 1 for every ACCESS cycle.
REQ-022 ACCESS write: oMemWriteEnable SHALL be 1 only in the first ACCESS cycle.
REQ-023 The wait counter SHALL increment once per ACCESS cycle; at count == WAIT_STATES the FSM SHALL capture iMemReadData (read) or 0 (write) into the oReadData register and go to DONE.
REQ-024 DONE: SHALL assert oAck[oGrant] for exactly one cycle, then go to IDLE.
REQ-025 Back-to-back: IDLE SHALL re-arbitrate in the cycle after DONE, so the request-to-ack latency is WAIT_STATES+2 cycles after the request is sampled in IDLE.
REQ-026 A channel that drops iReq during ACCESS SHALL still be completed and acked; other requests arriving meanwhile SHALL wait until IDLE.
REQ-027 Outside ACCESS, all memory enables SHALL be 0; oMemAddress, oMemByteEnable and oMemWriteData SHALL hold their latched values.
REQ-028 In DONE, the channel being acked SHALL NOT be re-granted in the same cycle; arbitration occurs only in IDLE.

Reset
REQ-029 While iRST=0, regardless of clock, the FSM SHALL be in IDLE, and oAck, oBusy, oGrant, oReadData, all memory enables and all latched registers SHALL be 0.
REQ-030 Reset asserted mid-ACCESS or mid-DONE SHALL abort the transaction with no oAck pulse.
REQ-031 After release, the first arbitration SHALL occur on the first rising edge with iRST=1.

Verification
REQ-032 Single read, WAIT_STATES=1: ch0 reads 0x100 and memory returns 0xDEADBEEF -> oMemReadEnable high 2 cycles, oAck=2'b01 at cycle 3, oReadData=0xDEADBEEF.
REQ-033 Write: ch1 writes 0x12345678 to 0x200 with byte enable 4'b0011 -> oMemWriteEnable high exactly 1 cycle, oMemByteEnable=4'b0011, oAck=2'b10, oReadData=0.
REQ-034 Fixed priority: ch0 and ch1 request continuously -> ch0 acked every WAIT_STATES+3 cycles; ch1 is never served while ch0 holds iReq.
REQ-035 Round-robin, NCH=4: all four request continuously -> grant order 0,1,2,3,0 with wrap-around, one ack each.
REQ-036 Reset mid-ACCESS: iRST=0 for 1 cycle during a ch0 read -> no oAck, enables drop immediately, oBusy=0; a re-held ch0 request is served normally after release.
REQ-037 WAIT_STATES=0: ch0 read -> 1 ACCESS cycle, oAck on cycle 2, back-to-back throughput of 1 transaction per 3 cycles.
